// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_SLT  = 4'b1010;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] REGSEL_ALU = 2'b00;
  localparam logic [1:0] REGSEL_MEM = 2'b01;
  localparam logic [1:0] REGSEL_PC4 = 2'b10;

  localparam logic [1:0] PCSEL_PC4 = 2'b00;
  localparam logic [1:0] PCSEL_IMM = 2'b01;
  localparam logic [1:0] PCSEL_ALU = 2'b10;

  // alt selects SUB/SRA over ADD/SRL (funct7 bit 5)
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational classification of the latched instruction word.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic        is_alu,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic        is_jal,
  output logic        is_jalr,
  output logic [3:0]  alu_ctrl,
  output logic        rs2_imm,
  output logic        br_use_lt,
  output logic        br_invert,
  output logic        bad
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;

  assign opcode        = ir[6:0];
  assign f3            = ir[14:12];
  assign f7            = ir[31:25];
  assign unused_fields = ^{ir[24:15], ir[11:7]};

  always_comb begin
    is_alu    = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    alu_ctrl  = ALU_ADD;
    rs2_imm   = 1'b0;
    br_use_lt = 1'b0;
    br_invert = 1'b0;
    bad       = 1'b1;
    case (opcode)
      OP_R: begin
        is_alu   = 1'b1;
        alu_ctrl = alu_from_funct3(f3, f7[5]);
        bad      = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OP_I: begin
        is_alu   = 1'b1;
        rs2_imm  = 1'b1;
        alu_ctrl = alu_from_funct3(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001)
          bad = (f7 != 7'h00);
        else if (f3 == 3'b101)
          bad = !((f7 == 7'h00) || (f7 == 7'h20));
        else
          bad = 1'b0;
      end
      // No access-size output exists, so only word loads/stores are accepted
      OP_LOAD: begin
        is_load = 1'b1;
        rs2_imm = 1'b1;
        bad     = (f3 != 3'b010);
      end
      OP_STORE: begin
        is_store = 1'b1;
        rs2_imm  = 1'b1;
        bad      = (f3 != 3'b010);
      end
      OP_BRANCH: begin
        is_branch = 1'b1;
        br_use_lt = f3[2];
        br_invert = f3[0];
        alu_ctrl  = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
        bad       = (f3[2:1] == 2'b01);
      end
      OP_JAL: begin
        is_jal = 1'b1;
        bad    = 1'b0;
      end
      OP_JALR: begin
        is_jalr = 1'b1;
        rs2_imm = 1'b1;
        bad     = (f3 != 3'b000);
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I controller: sequences fetch/decode/execute/memory/writeback.
// state  | meaning
// FETCH  | request instruction, latch IR on imem_ready
// DECODE | classify IR, trap on unsupported encodings
// EXEC   | drive ALU; branches/jumps update PC here
// MEM    | data access with timeout
// WB     | register write and PC+4
// TRAP   | sticky illegal, everything idle until reset
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  input  logic        dmem_ready,
  output logic        dmemwe,
  input  logic        alu_zero,
  input  logic        alu_lt,
  output logic [3:0]  ALUControl,
  output logic        rs2sel,
  output logic        regwe,
  output logic [1:0]  regsel,
  output logic        pcwe,
  output logic [1:0]  pcsel,
  output logic        illegal
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("multicycle_controller supports XLEN=32 only");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t           state, state_nxt;
  logic [31:0]      ir;
  logic [CNT_W-1:0] cnt;

  logic is_alu, is_load, is_store, is_branch, is_jal, is_jalr;
  logic [3:0] dec_alu;
  logic dec_rs2_imm, br_use_lt, br_invert, dec_bad;
  logic br_taken, timeout_hit;

  instr_decoder u_dec (
    .ir        (ir),
    .is_alu    (is_alu),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .is_jal    (is_jal),
    .is_jalr   (is_jalr),
    .alu_ctrl  (dec_alu),
    .rs2_imm   (dec_rs2_imm),
    .br_use_lt (br_use_lt),
    .br_invert (br_invert),
    .bad       (dec_bad)
  );

  assign br_taken    = (br_use_lt ? alu_lt : alu_zero) ^ br_invert;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && imem_ready)
        ir <= instr;
      if (state == MEM && state_nxt == MEM)
        cnt <= cnt + CNT_W'(1);
      else
        cnt <= '0;
    end
  end

  // ALU select and operand mux are held through MEM/WB so the result stays valid
  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmemwe     = 1'b0;
    ALUControl = ALU_ADD;
    rs2sel     = 1'b0;
    regwe      = 1'b0;
    regsel     = REGSEL_ALU;
    pcwe       = 1'b0;
    pcsel      = PCSEL_PC4;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        imem_req = reset;
        if (imem_ready)
          state_nxt = DECODE;
      end
      DECODE: state_nxt = dec_bad ? TRAP : EXEC;
      EXEC: begin
        ALUControl = dec_alu;
        rs2sel     = dec_rs2_imm;
        if (is_alu) begin
          state_nxt = WB;
        end else if (is_load || is_store) begin
          state_nxt = MEM;
        end else if (is_branch) begin
          pcwe      = 1'b1;
          pcsel     = br_taken ? PCSEL_IMM : PCSEL_PC4;
          state_nxt = FETCH;
        end else if (is_jal) begin
          regwe     = 1'b1;
          regsel    = REGSEL_PC4;
          pcwe      = 1'b1;
          pcsel     = PCSEL_IMM;
          state_nxt = FETCH;
        end else if (is_jalr) begin
          regwe     = 1'b1;
          regsel    = REGSEL_PC4;
          pcwe      = 1'b1;
          pcsel     = PCSEL_ALU;
          state_nxt = FETCH;
        end else begin
          state_nxt = TRAP;
        end
      end
      MEM: begin
        ALUControl = dec_alu;
        rs2sel     = dec_rs2_imm;
        dmem_req   = 1'b1;
        dmemwe     = is_store;
        if (dmem_ready) begin
          if (is_store) begin
            pcwe      = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = WB;
          end
        end else if (timeout_hit) begin
          state_nxt = TRAP;
        end
      end
      WB: begin
        ALUControl = dec_alu;
        rs2sel     = dec_rs2_imm;
        regwe      = 1'b1;
        regsel     = is_load ? REGSEL_MEM : REGSEL_ALU;
        pcwe       = 1'b1;
        state_nxt  = FETCH;
      end
      TRAP:    illegal = 1'b1;
      default: state_nxt = FETCH;
    endcase
  end

endmodule
